// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared backend types for the integer regfile writeback arbiter
package bp_be_pkg;

  typedef enum logic [0:0] {e_bp_inv_cfg} bp_params_e;

  function automatic int bp_dword_width(bp_params_e cfg);
    case (cfg)
      e_bp_inv_cfg: return 64;
      default:      return 64;
    endcase
  endfunction

  localparam int dword_width_gp = 64;

  typedef struct packed {
    logic                      rd_w_v;
    logic [4:0]                rd_addr;
    logic [dword_width_gp-1:0] rd_data;
  } bp_be_wb_pkt_s;

  typedef enum logic [1:0] {
    e_wb_src_none,
    e_wb_src_pipe,
    e_wb_src_ll,
    e_wb_src_cfg
  } bp_be_wb_src_e;

endpackage

// File: rtl/bp_be_wb_ll_fifo.sv
// rtl/bp_be_wb_ll_fifo.sv - circular FIFO for long-latency writebacks, entry array exposed
module bp_be_wb_ll_fifo
  import bp_be_pkg::*;
#(
  parameter int els_p = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  bp_be_wb_pkt_s data_i,
  input  logic          v_i,
  output logic          ready_o,
  output bp_be_wb_pkt_s data_o,
  output logic          v_o,
  input  logic          yumi_i,
  output bp_be_wb_pkt_s mem_o [els_p],
  output logic [els_p-1:0] mem_v_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [ptr_w_lp-1:0] rptr_q, wptr_q;
  logic [cnt_w_lp-1:0] cnt_q;
  bp_be_wb_pkt_s       mem_q [els_p];
  logic                full, empty, enq, deq;

  assign full    = (cnt_q == cnt_w_lp'(els_p));
  assign empty   = (cnt_q == '0);
  assign enq     = v_i & ~full;
  assign deq     = yumi_i & ~empty;
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q];
  assign mem_o   = mem_q;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else begin
      if (enq) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (deq) rptr_q <= ptr_inc(rptr_q);
      case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    mem_v_o = '0;
    for (int i = 0; i < els_p; i++)
      mem_v_o[i] = (((i + els_p - int'(rptr_q)) % els_p) < int'(cnt_q));
  end

endmodule

// File: rtl/bp_be_irf_wb_arbiter.sv
// rtl/bp_be_irf_wb_arbiter.sv - arbitrates pipe, long-latency and cfg writes onto the regfile port
module bp_be_irf_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
  parameter int         ll_fifo_els_p  = 2,
  parameter int         starve_limit_p = 4,
  localparam int        dword_width_p  = bp_dword_width(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  bp_be_wb_pkt_s            pipe_wb_pkt_i,
  input  bp_be_wb_pkt_s            ll_wb_pkt_i,
  input  logic                     ll_wb_v_i,
  output logic                     ll_wb_ready_o,
  input  logic                     cfg_w_v_i,
  input  logic [4:0]               cfg_w_addr_i,
  input  logic [dword_width_p-1:0] cfg_w_data_i,
  output logic                     cfg_w_yumi_o,
  output bp_be_wb_pkt_s            wb_pkt_o,
  output logic [31:0]              pending_rd_o,
  output logic                     stall_dispatch_o
);

  localparam int starve_w_lp = $clog2(starve_limit_p + 1);

  bp_be_wb_pkt_s              head, fifo_mem [ll_fifo_els_p];
  logic [ll_fifo_els_p-1:0]   fifo_mem_v;
  logic                       head_v, pipe_v;
  bp_be_wb_src_e              src;
  logic [starve_w_lp-1:0]     starve_q, starve_d;
  logic                       stall_q;

  bp_be_wb_ll_fifo #(.els_p(ll_fifo_els_p)) ll_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (ll_wb_pkt_i),
    .v_i     (ll_wb_v_i),
    .ready_o (ll_wb_ready_o),
    .data_o  (head),
    .v_o     (head_v),
    .yumi_i  (src == e_wb_src_ll),
    .mem_o   (fifo_mem),
    .mem_v_o (fifo_mem_v)
  );

  assign pipe_v = pipe_wb_pkt_i.rd_w_v;

  always_comb begin
    src = e_wb_src_none;
    if (!reset_i) begin
      if (pipe_v)         src = e_wb_src_pipe;
      else if (head_v)    src = e_wb_src_ll;
      else if (cfg_w_v_i) src = e_wb_src_cfg;
    end
  end

  assign cfg_w_yumi_o = (src == e_wb_src_cfg);

  // x0 writes are still consumed; only the regfile write enable is suppressed.
  always_comb begin
    wb_pkt_o = '0;
    case (src)
      e_wb_src_pipe: wb_pkt_o = '{rd_w_v: pipe_wb_pkt_i.rd_addr != 5'd0,
                                  rd_addr: pipe_wb_pkt_i.rd_addr, rd_data: pipe_wb_pkt_i.rd_data};
      e_wb_src_ll:   wb_pkt_o = '{rd_w_v: head.rd_w_v & (head.rd_addr != 5'd0),
                                  rd_addr: head.rd_addr, rd_data: head.rd_data};
      e_wb_src_cfg:  wb_pkt_o = '{rd_w_v: cfg_w_addr_i != 5'd0,
                                  rd_addr: cfg_w_addr_i, rd_data: cfg_w_data_i};
      default:       wb_pkt_o = '0;
    endcase
  end

  always_comb begin
    pending_rd_o = '0;
    for (int i = 0; i < ll_fifo_els_p; i++)
      if (fifo_mem_v[i] && fifo_mem[i].rd_w_v) pending_rd_o[fifo_mem[i].rd_addr] = 1'b1;
    pending_rd_o[0] = 1'b0;
  end

  // Any cycle the head is not blocked by the pipe it is either granted or absent.
  always_comb begin
    starve_d = '0;
    if (head_v && pipe_v)
      starve_d = (starve_q == starve_w_lp'(starve_limit_p)) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= (starve_d >= starve_w_lp'(starve_limit_p));
    end
  end

  assign stall_dispatch_o = stall_q;

endmodule
